// File: rtl/bidir_bus_ctrl.sv
// Half-duplex controller sharing one bidirectional pin between a write and a read stream.
// Arbitrates, inserts turnaround gaps on direction change and caps bursts when opposed.
module bidir_bus_ctrl #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned MAX_BURST   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_req,
    output logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [WIDTH-1:0] Dout,
    output logic             OE,
    input  logic [WIDTH-1:0] Din,
    output logic             dir
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam int unsigned TW = $clog2(TURN_CYCLES + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
    localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StTurn, StWrite, StRead} state_e;

    state_e          state_q, state_d;
    logic            dir_q, dir_d;
    logic            last_wr_q, last_wr_d;
    logic            to_wr_q, to_wr_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [TW-1:0]   turn_q, turn_d;

    logic             oe_q;
    logic [WIDTH-1:0] dout_q;
    logic             samp_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    logic want_any;
    logic want_wr;
    logic wr_acc;
    logic rd_acc;

    assign wr_ready = (state_q == StWrite);
    assign rd_ready = (state_q == StRead);
    assign wr_acc   = wr_ready & wr_valid;
    assign rd_acc   = rd_ready & rd_req;

    assign dir      = dir_q;
    assign OE       = oe_q;
    assign Dout     = dout_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        last_wr_d = last_wr_q;
        to_wr_d   = to_wr_q;
        burst_d   = burst_q;
        turn_d    = turn_q;
        want_any  = wr_valid | rd_req;
        // With both sides pending, serve the direction not served last time.
        want_wr   = (wr_valid & rd_req) ? ~last_wr_q : wr_valid;

        case (state_q)
            StIdle: begin
                if (want_any) begin
                    if (want_wr == dir_q) begin
                        state_d   = want_wr ? StWrite : StRead;
                        last_wr_d = want_wr;
                    end else begin
                        state_d = StTurn;
                        to_wr_d = want_wr;
                        turn_d  = '0;
                    end
                end
            end
            StTurn: begin
                if (turn_q == TURN_LAST) begin
                    state_d   = to_wr_q ? StWrite : StRead;
                    dir_d     = to_wr_q;
                    last_wr_d = to_wr_q;
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            StWrite: begin
                if (!wr_valid) begin
                    state_d = StIdle;
                    burst_d = '0;
                end else if (rd_req && burst_q >= BURST_LAST) begin
                    state_d = StIdle;
                    burst_d = '0;
                end else if (burst_q != BURST_MAX) begin
                    burst_d = burst_q + 1'b1;
                end
            end
            StRead: begin
                if (!rd_req) begin
                    state_d = StIdle;
                    burst_d = '0;
                end else if (wr_valid && burst_q >= BURST_LAST) begin
                    state_d = StIdle;
                    burst_d = '0;
                end else if (burst_q != BURST_MAX) begin
                    burst_d = burst_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            dir_q     <= 1'b0;
            last_wr_q <= 1'b0;
            to_wr_q   <= 1'b0;
            burst_q   <= '0;
            turn_q    <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            last_wr_q <= last_wr_d;
            to_wr_q   <= to_wr_d;
            burst_q   <= burst_d;
            turn_q    <= turn_d;
        end
    end

    // Beats use the pin the cycle after acceptance; reads land one cycle later still.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oe_q       <= 1'b0;
            dout_q     <= '0;
            samp_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            oe_q       <= wr_acc;
            samp_q     <= rd_acc;
            rd_valid_q <= samp_q;
            if (wr_acc) begin
                dout_q <= wr_data;
            end
            if (samp_q) begin
                rd_data_q <= Din;
            end
        end
    end

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Self-checking bench for bidir_bus_ctrl: vector table, directed corner sequences and
// randomized traffic compared against a behavioural beat-level model.
module tb_bidir_bus_ctrl;

    localparam int TURN = 1;
    localparam int MAXB = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic [3:0] wr_data;
    logic       wr_ready;
    logic       rd_req;
    logic       rd_ready;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic [3:0] Dout;
    logic       OE;
    logic [3:0] Din;
    logic       dir;

    bidir_bus_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_req   (rd_req),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .Dout     (Dout),
        .OE       (OE),
        .Din      (Din),
        .dir      (dir)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: who owns the pin, how long the current burst is, and the
    // pipeline of pin activity implied by accepted beats.
    int         m_mode;   // 0 idle, 1 turning, 2 writing, 3 reading
    int         m_dir, m_lastwr, m_tgt, m_tcnt, m_run;
    int         m_samp;
    logic       m_oe, m_rdv;
    logic [3:0] m_dout, m_rdd;

    task automatic model_reset();
        m_mode = 0; m_dir = 0; m_lastwr = 0; m_tgt = 0; m_tcnt = 0; m_run = 0;
        m_samp = 0; m_oe = 1'b0; m_rdv = 1'b0; m_dout = 4'h0; m_rdd = 4'h0;
    endtask

    task automatic model_step(input logic wv, input logic [3:0] wd, input logic rq,
                              input logic [3:0] din);
        int wacc, racc, want;
        wacc = (m_mode == 2 && wv) ? 1 : 0;
        racc = (m_mode == 3 && rq) ? 1 : 0;
        m_rdv = (m_samp != 0);
        if (m_samp != 0) m_rdd = din;
        m_samp = racc;
        m_oe = (wacc != 0);
        if (wacc != 0) m_dout = wd;
        if (m_mode == 0) begin
            if (wv || rq) begin
                want = (wv && rq) ? 1 - m_lastwr : (wv ? 1 : 0);
                if (want == m_dir) begin
                    m_mode = (want == 1) ? 2 : 3; m_lastwr = want; m_run = 0;
                end else begin
                    m_mode = 1; m_tgt = want; m_tcnt = 0;
                end
            end
        end else if (m_mode == 1) begin
            m_tcnt++;
            if (m_tcnt >= TURN) begin
                m_dir = m_tgt; m_lastwr = m_tgt; m_run = 0;
                m_mode = (m_tgt == 1) ? 2 : 3;
            end
        end else begin
            // own = this direction's request, opp = the other side pending
            if (!((m_mode == 2) ? wv : rq)) m_mode = 0;
            else begin
                m_run++;
                if (((m_mode == 2) ? rq : wv) && m_run >= MAXB) m_mode = 0;
            end
        end
    endtask

    logic       s_wrr, s_rdr, s_oe, s_rdv, s_dir;
    logic [3:0] s_dout, s_rdd;
    logic       prev_racc = 1'b0;
    logic       samp_now;
    int         cycn = 0;
    int         last_oe = -100;
    int         last_samp = -100;
    bit         chk_model = 1'b0;
    bit         inv_en = 1'b0;

    task automatic cyc(input logic wv, input logic [3:0] wd, input logic rq,
                       input logic [3:0] din);
        wr_valid = wv; wr_data = wd; rd_req = rq; Din = din;
        @(negedge clk);
        s_wrr = wr_ready; s_rdr = rd_ready; s_oe = OE; s_dout = Dout;
        s_rdv = rd_valid; s_rdd = rd_data; s_dir = dir;
        samp_now = prev_racc;
        if (inv_en) begin
            chk("ready_exclusive", int'(s_wrr && s_rdr), 0);
            chk("oe_vs_sample", int'(s_oe && samp_now), 0);
            if (samp_now) chk("gap_oe_to_sample", int'(cycn - last_oe - 1 >= TURN), 1);
            if (s_oe) chk("gap_sample_to_oe", int'(cycn - last_samp - 1 >= TURN), 1);
        end
        if (chk_model) begin
            chk("wr_ready", int'(s_wrr), int'(m_mode == 2));
            chk("rd_ready", int'(s_rdr), int'(m_mode == 3));
            chk("OE", int'(s_oe), int'(m_oe));
            chk("Dout", int'(s_dout), int'(m_dout));
            chk("dir", int'(s_dir), m_dir);
            chk("rd_valid", int'(s_rdv), int'(m_rdv));
            chk("rd_data", int'(s_rdd), int'(m_rdd));
        end
        @(posedge clk);
        prev_racc = rst_n && s_rdr && rq;
        if (!rst_n) model_reset();
        else model_step(wv, wd, rq, din);
        if (s_oe) last_oe = cycn;
        if (samp_now) last_samp = cycn;
        cycn++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b1, 4'h0, 1'b1, 4'h0);
        cyc(1'b1, 4'h0, 1'b1, 4'h0);
        chk("rst_OE", int'(s_oe), 0);
        chk("rst_Dout", int'(s_dout), 0);
        chk("rst_wr_ready", int'(s_wrr), 0);
        chk("rst_rd_ready", int'(s_rdr), 0);
        chk("rst_rd_valid", int'(s_rdv), 0);
        chk("rst_rd_data", int'(s_rdd), 0);
        chk("rst_dir", int'(s_dir), 0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       wv;
        logic [3:0] wd;
        logic       rq;
        logic [3:0] din;
        logic       wrr;
        logic       rdr;
        logic       oe;
        logic [3:0] dout;
        logic       dir;
        logic       rdv;
        logic [3:0] rdd;
    } vec_t;

    function automatic vec_t mk(input logic wv, input logic [3:0] wd, input logic rq,
                                input logic [3:0] din, input logic wrr, input logic rdr,
                                input logic oe, input logic [3:0] dout, input logic dr,
                                input logic rdv, input logic [3:0] rdd);
        vec_t v;
        v.wv = wv; v.wd = wd; v.rq = rq; v.din = din; v.wrr = wrr; v.rdr = rdr;
        v.oe = oe; v.dout = dout; v.dir = dr; v.rdv = rdv; v.rdd = rdd;
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        int  kinds[$];
        int  rk[$];
        int  rl[$];
        logic wv, rq;

        // write A,B,C from reset, then an immediate read of two beats
        tbl[0]  = mk(1'b1, 4'hA, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        tbl[1]  = mk(1'b1, 4'hA, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        tbl[2]  = mk(1'b1, 4'hA, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0);
        tbl[3]  = mk(1'b1, 4'hB, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 4'h0);
        tbl[4]  = mk(1'b1, 4'hC, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 4'h0);
        tbl[5]  = mk(1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 4'hC, 1'b1, 1'b0, 4'h0);
        tbl[6]  = mk(1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'hC, 1'b1, 1'b0, 4'h0);
        tbl[7]  = mk(1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'hC, 1'b1, 1'b0, 4'h0);
        tbl[8]  = mk(1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 4'hC, 1'b0, 1'b0, 4'h0);
        tbl[9]  = mk(1'b0, 4'h0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 4'hC, 1'b0, 1'b0, 4'h0);
        tbl[10] = mk(1'b0, 4'h0, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0, 4'hC, 1'b0, 1'b1, 4'h3);
        tbl[11] = mk(1'b0, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'hC, 1'b0, 1'b1, 4'h5);
        tbl[12] = mk(1'b0, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'hC, 1'b0, 1'b0, 4'h5);

        model_reset();
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = 4'h0; rd_req = 1'b0; Din = 4'h0;
        @(posedge clk);
        #1;
        do_reset();
        chk_model = 1'b1;
        inv_en = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].wv, tbl[i].wd, tbl[i].rq, tbl[i].din);
            chk($sformatf("tbl%0d_wr_ready", i), int'(s_wrr), int'(tbl[i].wrr));
            chk($sformatf("tbl%0d_rd_ready", i), int'(s_rdr), int'(tbl[i].rdr));
            chk($sformatf("tbl%0d_OE", i), int'(s_oe), int'(tbl[i].oe));
            chk($sformatf("tbl%0d_Dout", i), int'(s_dout), int'(tbl[i].dout));
            chk($sformatf("tbl%0d_dir", i), int'(s_dir), int'(tbl[i].dir));
            chk($sformatf("tbl%0d_rd_valid", i), int'(s_rdv), int'(tbl[i].rdv));
            chk($sformatf("tbl%0d_rd_data", i), int'(s_rdd), int'(tbl[i].rdd));
        end

        // both sides pending forever: bursts of MAXB alternate, write first
        do_reset();
        for (int i = 0; i < 70; i++) begin
            cyc(1'b1, 4'(i), 1'b1, 4'(i + 7));
            if (s_wrr) kinds.push_back(1);
            if (s_rdr) kinds.push_back(2);
        end
        foreach (kinds[i]) begin
            if (rk.size() == 0 || rk[rk.size() - 1] != kinds[i]) begin
                rk.push_back(kinds[i]);
                rl.push_back(1);
            end else begin
                rl[rl.size() - 1] = rl[rl.size() - 1] + 1;
            end
        end
        if (rk.size() < 3) begin
            chk("s4_run_count", rk.size(), 3);
        end else begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("s4_run%0d_kind", i), rk[i], (i % 2 == 0) ? 1 : 2);
                chk($sformatf("s4_run%0d_len", i), rl[i], MAXB);
            end
        end

        // write stream pauses mid-burst and resumes without a turnaround
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 4'(i + 1), 1'b0, 4'h0);
            if (i >= 2) chk("s5_wr_ready", int'(s_wrr), 1);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'h0, 1'b0, 4'h0);
            chk("s5_dir_hold", int'(s_dir), 1);
            chk("s5_no_rd", int'(s_rdr || s_rdv), 0);
        end
        cyc(1'b1, 4'h9, 1'b0, 4'h0);
        chk("s5_idle_before_resume", int'(s_wrr), 0);
        cyc(1'b1, 4'h9, 1'b0, 4'h0);
        chk("s5_resume_no_turn", int'(s_wrr), 1);
        chk("s5_resume_dir", int'(s_dir), 1);

        // reset lands in the middle of a 5-beat write
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'(i + 2), 1'b0, 4'h0);
        rst_n = 1'b0;
        cyc(1'b1, 4'h6, 1'b0, 4'h0);
        chk("s6_driving_before_rst", int'(s_oe), 1);
        rst_n = 1'b1;
        cyc(1'b1, 4'h7, 1'b0, 4'h0);
        chk("s6_oe_dropped", int'(s_oe), 0);
        chk("s6_dir_cleared", int'(s_dir), 0);
        chk("s6_idle_after_rst", int'(s_wrr), 0);
        cyc(1'b1, 4'h7, 1'b0, 4'h0);
        chk("s6_turn_after_rst", int'(s_wrr), 0);
        chk("s6_turn_oe", int'(s_oe), 0);
        cyc(1'b1, 4'h7, 1'b0, 4'h0);
        chk("s6_write_after_turn", int'(s_wrr), 1);
        chk("s6_dir_out", int'(s_dir), 1);
        cyc(1'b0, 4'h0, 1'b0, 4'h0);
        chk("s6_new_beat_driven", int'(s_oe), 1);
        chk("s6_new_beat_data", int'(s_dout), 7);

        // randomized traffic against the model
        wv = 1'b0; rq = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) wv = ~wv;
            if ($urandom_range(0, 5) == 0) rq = ~rq;
            rst_n = ($urandom_range(0, 499) != 0);
            cyc(wv, 4'($urandom), rq, 4'($urandom));
        end
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bidir_bus_ctrl.md
Name: bidir_bus_ctrl

Overview:
- Half-duplex controller for the team's 4-bit bidirectional pin driver (Dout/OE out, Din in).
- Shares the single pin between a write stream (valid/ready) and a read stream (req/ready, returned data).
- Arbitrates between the two and enforces bus-turnaround gaps so the controller and the external device never drive simultaneously.
- Limits burst length so neither direction starves the other.

Parameters:
WIDTH, 4, bus/data width
TURN_CYCLES, 1, minimum OE=0 idle cycles at every direction change (>=1)
MAX_BURST, 8, max consecutive beats in one direction while the other side is pending (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
wr_valid  input  1  write beat offered
wr_data  input  WIDTH  write beat data
wr_ready  output  1  write beat accepted this cycle when wr_valid=1
rd_req  input  1  read beat requested
rd_ready  output  1  read beat accepted this cycle when rd_req=1
rd_data  output  WIDTH  captured read data
rd_valid  output  1  one-cycle pulse, rd_data valid
Dout  output  WIDTH  to pin driver, data to drive
OE  output  1  to pin driver, 1 = drive pin
Din  input  WIDTH  from pin driver, pin value
dir  output  1  current bus direction, 1 = out (write), 0 = in (read)

Behaviour:
- Clock/reset: one clock `clk`; reset `rst_n` is synchronous and active-low. When rst_n=0 at an edge:
  - OE=0, Dout=0, rd_valid=0, rd_data=0, wr_ready=0, rd_ready=0.
  - dir=0; state=IDLE; burst count=0; arbitration preference=write.
  - In-flight beats are dropped.
- Grant-to-bus timing: a beat accepted in cycle c uses the bus in cycle c+1.
  - Write accepted in c: Dout=wr_data and OE=1 during c+1 (both registered). In any cycle without an accepted write in c-1, OE=0; Dout holds its last value.
  - Read accepted in c: Din is sampled at the end of c+1; rd_data updates and rd_valid=1 during c+2.
  - Throughput is one beat per cycle in either direction.
- States:
  - IDLE: wr_ready=rd_ready=0.
    - Only wr_valid: next = WRITE if dir=1, else TURN toward out.
    - Only rd_req: next = READ if dir=0, else TURN toward in.
    - Both pending: serve the direction opposite to the last one served (write after reset), via TURN if dir differs.
  - TURN: wr_ready=rd_ready=0, OE=0 for at least TURN_CYCLES cycles after the last bus-use cycle of the old direction. Then dir flips and the state enters the target (WRITE/READ). The target is fixed on entry, even if its request drops; it then exits normally.
  - WRITE (dir=1): wr_ready=1.
    - Each accepted beat increments the burst count.
    - Exit to IDLE when wr_valid=0 in a cycle, or when burst count reaches MAX_BURST while rd_req=1.
    - Burst count clears on exit.
  - READ (dir=0): rd_ready=1. Symmetric to WRITE with rd_req, counting against wr_valid.
- Turnaround invariant:
  - Between the last OE=1 cycle and the first Din sample cycle, there are at least TURN_CYCLES cycles with OE=0.
  - Between the last Din sample cycle and the first OE=1 cycle, there are at least TURN_CYCLES cycles with OE=0.
- No direction change without TURN. Repeat bursts in the same direction go IDLE→WRITE/READ with no TURN.
- wr_ready and rd_ready are never both 1. OE=1 never coincides with a Din sample cycle.
- Burst cap applies only when the other side is pending; an unopposed stream runs unbounded.
- If wr_valid/rd_req drops during TURN, the target state still completes one cycle and exits.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with wr_valid=rd_req=1 -> OE=0, Dout=0, wr_ready=rd_ready=0, rd_valid=0, dir=0.
2. After reset, write burst 0xA,0xB,0xC (wr_valid from cycle 0) -> cycle 0 IDLE, cycle 1 TURN, wr_ready=1 cycles 2-4, OE=1 cycles 3-5 with Dout=A,B,C, OE=0 cycle 6, dir=1.
3. Read right after step 2 (rd_req from cycle 5) -> no rd_ready before cycle 7. First sample cycle ≥ 8, preceded by ≥1 OE=0 cycle. rd_data equals the Din values driven by the bench, one rd_valid pulse per beat.
4. Both wr_valid and rd_req held high continuously -> bursts alternate: exactly 8 writes, turnaround, 8 reads, turnaround, and so on. No cycle has OE=1 and a Din sample together.
5. wr_valid drops mid-burst after 2 beats, reasserts 3 cycles later -> return to IDLE, dir stays 1, re-enter WRITE without TURN, and no rd activity.
6. rst_n=0 asserted in the middle of a 5-beat write -> OE=0 in the next cycle and the remaining beats are not driven. After release, a new write goes through TURN since dir=0.
